// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA fade types and constants
package vga_pkg;

   localparam logic [4:0] FADE_LEVEL_MAX = 5'd16;

   typedef enum logic [1:0] {
      IDLE,
      FADE_OUT,
      HOLD,
      FADE_IN
   } fade_state_t;

endpackage

// File: rtl/vga_if.sv
// rtl/vga_if.sv - VGA timing and rgb bundle passed between screen stages
interface vga_if;
   logic [10:0] vcount;
   logic        vsync;
   logic        vblnk;
   logic [10:0] hcount;
   logic        hsync;
   logic        hblnk;
   logic [11:0] rgb;

   modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
   modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/rgb_scale.sv
// rtl/rgb_scale.sv - scales each 4-bit channel by level/16, truncating
module rgb_scale (
   input  logic [11:0] rgb_in,
   input  logic [4:0]  level,
   output logic [11:0] rgb_out
);

   function automatic logic [3:0] scale_channel(input logic [3:0] c, input logic [4:0] l);
      logic [8:0] prod;
      prod = {5'd0, c} * {4'd0, l};
      return 4'(prod >> 4);
   endfunction

   always_comb begin
      rgb_out = '0;
      rgb_out[11:8] = scale_channel(rgb_in[11:8], level);
      rgb_out[7:4]  = scale_channel(rgb_in[7:4],  level);
      rgb_out[3:0]  = scale_channel(rgb_in[3:0],  level);
   end

endmodule

// File: rtl/screen_fade.sv
// rtl/screen_fade.sv - frame-locked fade-out / black hold / fade-in between screens
module screen_fade
   import vga_pkg::*;
#(
   parameter int HOLD_FRAMES = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   vga_if.in    vga_in,
   vga_if.out   vga_out,
   output logic busy,
   output logic black,
   output logic done
);

   fade_state_t state;
   logic [4:0]  level;
   logic [7:0]  hold_cnt;
   logic        vblnk_prev;
   logic        frame_tick;
   logic [11:0] rgb_scaled;

   assign frame_tick = vga_in.vblnk & ~vblnk_prev;

   rgb_scale u_rgb_scale (
      .rgb_in  (vga_in.rgb),
      .level   (level),
      .rgb_out (rgb_scaled)
   );

   // Level only moves on the vblank rising edge so a frame is never split.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         level      <= FADE_LEVEL_MAX;
         hold_cnt   <= 8'd0;
         vblnk_prev <= 1'b0;
         busy       <= 1'b0;
         black      <= 1'b0;
         done       <= 1'b0;
      end else begin
         vblnk_prev <= vga_in.vblnk;
         done       <= 1'b0;
         case (state)
            IDLE: begin
               level <= FADE_LEVEL_MAX;
               black <= 1'b0;
               busy  <= start;
               if (start)
                  state <= FADE_OUT;
            end
            FADE_OUT: begin
               if (frame_tick) begin
                  level <= level - 5'd1;
                  if (level == 5'd1) begin
                     state    <= HOLD;
                     hold_cnt <= 8'd0;
                     black    <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (frame_tick) begin
                  hold_cnt <= hold_cnt + 8'd1;
                  if (hold_cnt == 8'(HOLD_FRAMES - 1)) begin
                     state <= FADE_IN;
                     black <= 1'b0;
                  end
               end
            end
            FADE_IN: begin
               if (frame_tick) begin
                  level <= level + 5'd1;
                  if (level == FADE_LEVEL_MAX - 5'd1) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vga_out.vcount <= '0;
         vga_out.vsync  <= 1'b0;
         vga_out.vblnk  <= 1'b0;
         vga_out.hcount <= '0;
         vga_out.hsync  <= 1'b0;
         vga_out.hblnk  <= 1'b0;
         vga_out.rgb    <= '0;
      end else begin
         vga_out.vcount <= vga_in.vcount;
         vga_out.vsync  <= vga_in.vsync;
         vga_out.vblnk  <= vga_in.vblnk;
         vga_out.hcount <= vga_in.hcount;
         vga_out.hsync  <= vga_in.hsync;
         vga_out.hblnk  <= vga_in.hblnk;
         vga_out.rgb    <= (vga_in.vblnk || vga_in.hblnk) ? 12'h000 : rgb_scaled;
      end
   end

endmodule

// File: tb/tb_screen_fade.sv
// tb/tb_screen_fade.sv - directed and table-driven checks for screen_fade
module tb_screen_fade;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic busy;
   logic black;
   logic done;

   vga_if vin ();
   vga_if vout ();

   screen_fade #(.HOLD_FRAMES(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .vga_in  (vin),
      .vga_out (vout),
      .busy    (busy),
      .black   (black),
      .done    (done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [10:0] hc;
      logic [10:0] vc;
      logic        hs;
      logic        vs;
      logic        hb;
      logic        vb;
      logic [11:0] rgb;
      logic [11:0] exp_rgb;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [10:0] hc, input logic [10:0] vc, input logic hs,
                        input logic vs, input logic hb, input logic vb, input logic [11:0] rgb);
      vin.hcount = hc;
      vin.vcount = vc;
      vin.hsync  = hs;
      vin.vsync  = vs;
      vin.hblnk  = hb;
      vin.vblnk  = vb;
      vin.rgb    = rgb;
   endtask

   task automatic check_timing(input string name, input vec_t v);
      chk({name, "_hcount"}, 32'(vout.hcount), 32'(v.hc));
      chk({name, "_vcount"}, 32'(vout.vcount), 32'(v.vc));
      chk({name, "_syncblnk"}, {28'd0, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk},
          {28'd0, v.hs, v.vs, v.hb, v.vb});
      chk({name, "_rgb"}, 32'(vout.rgb), 32'(v.exp_rgb));
   endtask

   // Start a sequence (with a coincident vblank edge that must not count),
   // then run 40 frame ticks and watch black/done/busy and the fade level.
   task automatic run_sequence(input bit extra_starts);
      int black_ticks = 0;
      int done_cnt = 0;
      drive(11'd10, 11'd10, 1'b0, 1'b0, 1'b0, 1'b0, 12'hff0);
      start = 1'b1;
      vin.vblnk = 1'b1;
      step();
      start = 1'b0;
      chk("seq_busy_after_start", 32'(busy), 32'd1);
      vin.vblnk = 1'b0;
      step();
      chk("seq_start_tick_ignored", 32'(vout.rgb), 32'h0ff0);
      for (int t = 1; t <= 40; t++) begin
         vin.vblnk = 1'b1;
         start = extra_starts && (t == 3 || t == 20);
         step();
         start = 1'b0;
         if (black) black_ticks++;
         if (done) done_cnt++;
         if (t == 40) begin
            chk("seq_done_at_tick40", 32'(done), 32'd1);
            chk("seq_busy_falls_with_done", 32'(busy), 32'd0);
         end
         vin.vblnk = 1'b0;
         step();
         if (done) done_cnt++;
         if (t == 8)  chk("seq_level8_rgb", 32'(vout.rgb), 32'h0770);
         if (t == 16) begin
            chk("seq_black_at16", 32'(black), 32'd1);
            chk("seq_level0_rgb", 32'(vout.rgb), 32'h0000);
         end
         if (t == 24) chk("seq_black_clear_at24", 32'(black), 32'd0);
         if (t == 39) chk("seq_busy_before_end", 32'(busy), 32'd1);
      end
      chk("seq_black_ticks", 32'(black_ticks), 32'd8);
      chk("seq_done_count", 32'(done_cnt), 32'd1);
      step();
      chk("seq_done_low_after", 32'(done), 32'd0);
      chk("seq_full_level_after", 32'(vout.rgb), 32'h0ff0);
   endtask

   initial begin
      vec_t prev;
      vec_t cur;
      int done_seen;

      tbl[0] = '{hc: 11'd0,   vc: 11'd0,   hs: 1'b0, vs: 1'b0, hb: 1'b0, vb: 1'b0, rgb: 12'h123, exp_rgb: 12'h123};
      tbl[1] = '{hc: 11'd1,   vc: 11'd0,   hs: 1'b0, vs: 1'b0, hb: 1'b0, vb: 1'b0, rgb: 12'hfff, exp_rgb: 12'hfff};
      tbl[2] = '{hc: 11'd800, vc: 11'd0,   hs: 1'b0, vs: 1'b0, hb: 1'b1, vb: 1'b0, rgb: 12'habc, exp_rgb: 12'h000};
      tbl[3] = '{hc: 11'd840, vc: 11'd0,   hs: 1'b1, vs: 1'b0, hb: 1'b1, vb: 1'b0, rgb: 12'hfff, exp_rgb: 12'h000};
      tbl[4] = '{hc: 11'd5,   vc: 11'd600, hs: 1'b0, vs: 1'b0, hb: 1'b0, vb: 1'b1, rgb: 12'h5a5, exp_rgb: 12'h000};
      tbl[5] = '{hc: 11'd6,   vc: 11'd601, hs: 1'b0, vs: 1'b1, hb: 1'b1, vb: 1'b1, rgb: 12'h777, exp_rgb: 12'h000};
      tbl[6] = '{hc: 11'd2,   vc: 11'd1,   hs: 1'b0, vs: 1'b0, hb: 1'b0, vb: 1'b0, rgb: 12'h0f0, exp_rgb: 12'h0f0};
      tbl[7] = '{hc: 11'h7ff, vc: 11'h7ff, hs: 1'b1, vs: 1'b1, hb: 1'b0, vb: 1'b0, rgb: 12'h801, exp_rgb: 12'h801};

      // Reset with busy inputs; outputs must all be cleared.
      rst = 1'b1;
      start = 1'b0;
      drive(11'd55, 11'd66, 1'b1, 1'b1, 1'b0, 1'b1, 12'hfff);
      repeat (3) step();
      chk("rst_timing", {20'd0, vout.hcount, 1'b0}, 32'd0);
      chk("rst_vcount", 32'(vout.vcount), 32'd0);
      chk("rst_flags", {28'd0, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}, 32'd0);
      chk("rst_rgb", 32'(vout.rgb), 32'd0);
      chk("rst_busy_black_done", {29'd0, busy, black, done}, 32'd0);
      rst = 1'b0;
      drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0f0);
      step();
      chk("rst_first_pixel", 32'(vout.rgb), 32'h00f0);

      // Table vectors in IDLE: one-cycle latency, blanking forces black.
      prev = tbl[6];
      prev.hc = 11'd0; prev.vc = 11'd0; prev.hs = 1'b0; prev.vs = 1'b0;
      prev.hb = 1'b0; prev.vb = 1'b0; prev.rgb = 12'h0f0; prev.exp_rgb = 12'h0f0;
      for (int i = 0; i < 8; i++) begin
         drive(tbl[i].hc, tbl[i].vc, tbl[i].hs, tbl[i].vs, tbl[i].hb, tbl[i].vb, tbl[i].rgb);
         #1;
         chk($sformatf("tbl%0d_latency_hold", i), 32'(vout.hcount), 32'(prev.hc));
         step();
         check_timing($sformatf("tbl%0d", i), tbl[i]);
         prev = tbl[i];
      end

      // Random timing for a couple of frames' worth of cycles in IDLE.
      for (int i = 0; i < 60; i++) begin
         cur.hc  = 11'($urandom);
         cur.vc  = 11'($urandom);
         cur.hs  = 1'($urandom);
         cur.vs  = 1'($urandom);
         cur.hb  = ($urandom_range(0, 3) == 0);
         cur.vb  = (i >= 25 && i < 30);
         cur.rgb = 12'($urandom);
         cur.exp_rgb = (cur.hb || cur.vb) ? 12'h000 : cur.rgb;
         drive(cur.hc, cur.vc, cur.hs, cur.vs, cur.hb, cur.vb, cur.rgb);
         step();
         check_timing($sformatf("rand%0d", i), cur);
      end
      chk("idle_busy_low", 32'(busy), 32'd0);

      run_sequence(1'b0);
      run_sequence(1'b1);

      // Reset during FADE_IN at level 5 aborts without a done pulse.
      drive(11'd10, 11'd10, 1'b0, 1'b0, 1'b0, 1'b0, 12'hff0);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int t = 1; t <= 29; t++) begin
         vin.vblnk = 1'b1;
         step();
         vin.vblnk = 1'b0;
         step();
      end
      chk("abort_level5_rgb", 32'(vout.rgb), 32'h0440);
      chk("abort_busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_rgb_cleared", 32'(vout.rgb), 32'd0);
      step();
      chk("abort_level16", 32'(vout.rgb), 32'h0ff0);
      done_seen = 0;
      for (int t = 0; t < 20; t++) begin
         vin.vblnk = 1'b1;
         step();
         if (done) done_seen++;
         vin.vblnk = 1'b0;
         step();
         if (done) done_seen++;
      end
      chk("abort_no_done", 32'(done_seen), 32'd0);
      chk("abort_stays_idle", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/screen_fade.md
SCREEN_FADE -- requirements
Module: screen_fade

Interface
REQ-001 Parameter HOLD_FRAMES, default 8, number of fully black frames between fade-out and fade-in (legal 1..255).
REQ-002 clk  input  1  system pixel clock; all logic on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a fade-out/hold/fade-in sequence.
REQ-005 vga_in  vga_if.in  -  upstream timing and rgb (vcount, vsync, vblnk, hcount, hsync, hblnk, rgb[11:0]), fed by the start screen stage.
REQ-006 vga_out  vga_if.out  -  same fields, rgb scaled by the current fade level.
REQ-007 busy  output  1  high in any state other than IDLE.
REQ-008 black  output  1  high while in HOLD; marks when the game may swap the upstream screen.
REQ-009 done  output  1  one-cycle pulse when the sequence returns to IDLE.

Function
REQ-010 Frame tick = vga_in.vblnk high while its registered previous value is low; the fade level changes only on a frame tick, so it never changes mid-frame.
REQ-011 Level: 5-bit unsigned, range 0..16; 16 = full brightness, 0 = black.
REQ-012 Scaling per 4-bit channel: out = (in * level) >> 4, 9-bit intermediate, truncated; level 16 gives out = in exactly.
REQ-013 Latency: every vga_out field equals the vga_in value of one clock earlier; timing fields pass unmodified.
REQ-014 When vga_in.vblnk or vga_in.hblnk is high, vga_out.rgb shall be 12'h000 regardless of level.
REQ-015 States: IDLE, FADE_OUT, HOLD, FADE_IN.
REQ-016 IDLE: level = 16; start -> FADE_OUT on the next clock; a frame tick in the same cycle as start does not decrement.
REQ-017 FADE_OUT: each tick, level decrements by 1; the tick that makes level 0 also moves the FSM to HOLD with the hold counter cleared to 0.
REQ-018 HOLD: level = 0; each tick increments the hold counter; the tick on which the counter equals HOLD_FRAMES-1 moves the FSM to FADE_IN.
REQ-019 FADE_IN: each tick, level increments by 1; the tick that makes level 16 moves the FSM to IDLE and asserts done for exactly that following cycle.
REQ-020 start is ignored in every state except IDLE; no queuing.
REQ-021 Total sequence = 16 + HOLD_FRAMES + 16 frame ticks after start.
REQ-022 busy, black and done are registered outputs, consistent with the FSM state in the same cycle.

Reset
REQ-023 On rst: state IDLE, level 16, hold counter 0, previous-vblnk 0, busy/black/done 0, all vga_out fields 0.
REQ-024 rst asserted mid-sequence aborts it: the next cycle is IDLE at level 16, with no done pulse.

Structure
REQ-025 The fade state enum and FADE_LEVEL_MAX = 16 shall live in vga_pkg.
REQ-026 One combinational sub-module, rgb_scale (12-bit rgb in, 5-bit level in, 12-bit rgb out), instantiated once; the FSM, tick detector and output register stay in screen_fade.

Verification
REQ-027 Reset: hold rst 3 cycles -> all vga_out fields 0, busy=0, level 16; first active pixel rgb 12'h0f0 in -> 12'h0f0 out one clock later.
REQ-028 Pass-through: in IDLE, random timing for 2 frames -> vga_out equals vga_in delayed by 1 cycle; rgb is 0 in blanking.
REQ-029 Fade-out: pulse start, run 8 frame ticks -> level 8, input 12'hff0 gives 12'h770; after 16 ticks black=1 and active rgb = 12'h000.
REQ-030 Full sequence (HOLD_FRAMES=8): start -> black high for exactly 8 frames; done pulses once, 1 cycle wide, after tick 40; busy falls in the same cycle.
REQ-031 start pulsed during FADE_OUT and during HOLD -> no effect on level or timing; done still appears after tick 40 counted from the first start.
REQ-032 rst at level 5 during FADE_IN -> next cycle state IDLE, level 16, busy=0, and no done pulse.
